// File: rtl/pipeline_pkg.sv
// Shared definitions for the framebuffer write path: default geometry, the
// buffered pixel entry layout, arbiter state encoding and address helper.
package pipeline_pkg;

  localparam int DEF_PRECISION    = 11;
  localparam int DEF_PIXEL_SIZE   = 16;
  localparam int DEF_RESOLUTION_X = 800;

  typedef struct packed {
    logic [DEF_PRECISION-1:0]  x;
    logic [DEF_PRECISION-1:0]  y;
    logic [DEF_PIXEL_SIZE-1:0] pixel;
  } pixel_entry_t;

  localparam int ENTRY_W = $bits(pixel_entry_t);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_BUSY = 2'b01
  } arb_state_e;

  // Linear word address; the caller truncates to its SRAM address width.
  function automatic logic [31:0] pixel_address(input logic [DEF_PRECISION-1:0] x,
                                                input logic [DEF_PRECISION-1:0] y,
                                                input int                       stride);
    return 32'(y) * 32'(stride) + 32'(x);
  endfunction

endpackage

// File: rtl/pipeline_sram_write_arbiter_if.sv
// Request/acknowledge SRAM write port: the arbiter is master, the SRAM
// controller is slave.
interface pipeline_sram_write_arbiter_if
  import pipeline_pkg::*;
#(
  parameter int ADDRESS_SIZE = 19,
  parameter int PIXEL_SIZE   = DEF_PIXEL_SIZE
);
  logic [ADDRESS_SIZE-1:0] addr;
  logic [PIXEL_SIZE-1:0]   data;
  logic                    req;
  logic                    ack;

  modport master (output addr, output data, output req, input ack);
  modport slave  (input addr, input data, input req, output ack);
endinterface

// File: rtl/pipeline_pixel_fifo.sv
// Small first-word-fall-through FIFO for one pixel producer. A push into a
// full FIFO is accepted only when the head is popped in the same cycle.
module pipeline_pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipeline_sram_write_arbiter.sv
// Buffers the capture and SPI-upload pixel streams and drains them into the
// single SRAM write port with fixed fg priority and an img starvation guard.
module pipeline_sram_write_arbiter
  import pipeline_pkg::*;
#(
  parameter int PRECISION    = DEF_PRECISION,
  parameter int PIXEL_SIZE   = DEF_PIXEL_SIZE,
  parameter int RESOLUTION_X = DEF_RESOLUTION_X,
  parameter int ADDRESS_SIZE = 19,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_SIZE-1:0] fg_pixel,
  input  logic [PRECISION-1:0]  fg_x,
  input  logic [PRECISION-1:0]  fg_y,
  input  logic                  fg_valid,
  input  logic [PIXEL_SIZE-1:0] img_pixel,
  input  logic [PRECISION-1:0]  img_x,
  input  logic [PRECISION-1:0]  img_y,
  input  logic                  img_valid,
  input  logic                  clear_overflow,
  pipeline_sram_write_arbiter_if.master sram,
  output logic                  fg_overflow,
  output logic                  img_overflow,
  output logic                  busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  pixel_entry_t    fg_din, img_din, fg_dout, img_dout, granted;
  logic            fg_full, fg_empty, img_full, img_empty;
  logic            fg_pop, img_pop;
  logic            grant_slot, pick_img, any_pending;
  arb_state_e      state, state_next;
  logic [SW-1:0]   starve_cnt;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [PIXEL_SIZE-1:0]   data_q;

  assign fg_din  = '{x: fg_x,  y: fg_y,  pixel: fg_pixel};
  assign img_din = '{x: img_x, y: img_y, pixel: img_pixel};

  pipeline_pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fg_fifo (
    .clk(clk), .rst(rst), .push(fg_valid), .pop(fg_pop),
    .din(fg_din), .dout(fg_dout), .full(fg_full), .empty(fg_empty)
  );

  pipeline_pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_img_fifo (
    .clk(clk), .rst(rst), .push(img_valid), .pop(img_pop),
    .din(img_din), .dout(img_dout), .full(img_full), .empty(img_empty)
  );

  assign any_pending = !fg_empty || !img_empty;
  // img wins when it is alone or has waited through STARVE_LIMIT fg grants.
  assign pick_img    = !img_empty && (fg_empty || starve_cnt == SW'(STARVE_LIMIT));
  assign granted     = pick_img ? img_dout : fg_dout;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    grant_slot = 1'b0;
    fg_pop     = 1'b0;
    img_pop    = 1'b0;
    case (state)
      ARB_IDLE: begin
        grant_slot = 1'b1;
        if (any_pending) state_next = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (sram.ack) begin
          grant_slot = 1'b1;
          state_next = any_pending ? ARB_BUSY : ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
    if (grant_slot && any_pending) begin
      img_pop = pick_img;
      fg_pop  = !pick_img;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      starve_cnt   <= '0;
      fg_overflow  <= 1'b0;
      img_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (fg_pop || img_pop) begin
        addr_q <= ADDRESS_SIZE'(pixel_address(granted.x, granted.y, RESOLUTION_X));
        data_q <= granted.pixel;
      end
      if (img_empty || img_pop)
        starve_cnt <= '0;
      else if (fg_pop)
        starve_cnt <= starve_cnt + SW'(1);
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      fg_overflow  <= (fg_overflow  && !clear_overflow) || (fg_valid  && fg_full  && !fg_pop);
      img_overflow <= (img_overflow && !clear_overflow) || (img_valid && img_full && !img_pop);
    end
  end

  assign sram.req  = (state == ARB_BUSY);
  assign sram.addr = addr_q;
  assign sram.data = data_q;
  assign busy      = any_pending || sram.req;

endmodule
